ip_udp_hdr_gen: RTL

IP_UDP_HDR_GEN -- requirements
Module: ip_udp_hdr_gen

---
 rtl/eth_hdr_pkg.sv | 51 +++++
 rtl/ip_csum_acc.sv | 38 +++
 rtl/ip_udp_hdr_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/eth_hdr_pkg.sv
// Shared constants, FSM state type and IPv4 header word selector for the
// Ethernet/IPv4/UDP header generator.
package eth_hdr_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
    localparam logic [15:0] ETHERTYPE_VLAN  = 16'h8100;
    localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
    localparam logic [15:0] MAX_UDP_PAYLOAD = 16'd1472;
    localparam logic [15:0] IP_VER_IHL_TOS  = 16'h4500;
    localparam logic [15:0] IP_FLAGS_DF     = 16'h4000;

    localparam int ETH_HDR_BYTES  = 14;
    localparam int VLAN_TAG_BYTES = 4;
    localparam int IP_HDR_BYTES   = 20;
    localparam int UDP_HDR_BYTES  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FOLD,
        ST_SEND
    } hdr_state_t;

    // The ten 16-bit words of the IPv4 header; word 5 is the checksum slot.
    function automatic logic [15:0] ip_word(
        input logic [3:0]  idx,
        input logic [15:0] tot_len,
        input logic [15:0] id,
        input logic [7:0]  ttl,
        input logic [31:0] sip,
        input logic [31:0] dip,
        input logic [15:0] csum
    );
        logic [15:0] w;
        case (idx)
            4'd0:    w = IP_VER_IHL_TOS;
            4'd1:    w = tot_len;
            4'd2:    w = id;
            4'd3:    w = IP_FLAGS_DF;
            4'd4:    w = {ttl, IP_PROTO_UDP};
            4'd5:    w = csum;
            4'd6:    w = sip[31:16];
            4'd7:    w = sip[15:0];
            4'd8:    w = dip[31:16];
            4'd9:    w = dip[15:0];
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Ones-complement checksum: 20-bit accumulate, end-around-carry fold, and a
// final fold+invert step that registers the 16-bit checksum.
module ip_csum_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_add,
    input  logic [15:0] i_word,
    input  logic        i_fold,
    input  logic        i_finish,
    output logic [15:0] o_csum
);

    logic [19:0] r_acc;
    logic [15:0] r_csum;
    logic [19:0] w_folded;

    // Ten 16-bit words cannot overflow 20 bits, and two folds always fit 16.
    assign w_folded = {4'h0, r_acc[15:0]} + {16'h0000, r_acc[19:16]};
    assign o_csum   = r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_csum <= '0;
        end else if (i_clear) begin
            r_acc  <= '0;
            r_csum <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + {4'h0, i_word};
        end else if (i_fold) begin
            r_acc <= w_folded;
        end else if (i_finish) begin
            r_csum <= ~w_folded[15:0];
        end
    end

endmodule

// File: rtl/ip_udp_hdr_gen.sv
// Ethernet + IPv4 + UDP header generator streaming BUS_W-bit beats.
// Optional 802.1Q tag insertion is enabled by defining VLAN_TAG_EN.
module ip_udp_hdr_gen
    import eth_hdr_pkg::*;
#(
    parameter int          BUS_W    = 16,
    parameter logic [7:0]  TTL      = 8'd64,
    parameter logic [15:0] VLAN_TCI = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [47:0]      dst_mac,
    input  logic [47:0]      src_mac,
    input  logic [31:0]      dst_ip,
    input  logic [31:0]      src_ip,
    input  logic [15:0]      src_port,
    input  logic [15:0]      dst_port,
    input  logic [15:0]      ip_id,
    input  logic [15:0]      payload_len,
    output logic [BUS_W-1:0] hdr_data,
    output logic             hdr_valid,
    output logic             hdr_last,
    input  logic             hdr_ready,
    output logic             busy,
    output logic             len_err
);

`ifdef VLAN_TAG_EN
    localparam int HDR_BYTES = ETH_HDR_BYTES + VLAN_TAG_BYTES + IP_HDR_BYTES + UDP_HDR_BYTES;
`else
    localparam int HDR_BYTES = ETH_HDR_BYTES + IP_HDR_BYTES + UDP_HDR_BYTES;
`endif
    localparam int         NBEATS    = HDR_BYTES / (BUS_W / 8);
    localparam logic [5:0] LAST_BEAT = 6'(NBEATS - 1);

    hdr_state_t       r_state;
    logic [3:0]       r_cnt;
    logic [5:0]       r_beat;
    logic [47:0]      r_dst_mac, r_src_mac;
    logic [31:0]      r_dst_ip, r_src_ip;
    logic [15:0]      r_src_port, r_dst_port, r_ip_id, r_ip_len, r_udp_len;
    logic             r_busy, r_len_err, r_hdr_valid, r_hdr_last;
    logic [BUS_W-1:0] r_hdr_data;

    logic [15:0]      w_csum, w_calc_word, w_word;
    logic [4:0]       w_word_idx, w_k;
    logic [3:0]       w_ip_off;
    logic [BUS_W-1:0] w_beat;

    assign w_calc_word = ip_word(r_cnt, r_ip_len, r_ip_id, TTL, r_src_ip, r_dst_ip, 16'h0000);

    ip_csum_acc u_csum (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state == ST_IDLE),
        .i_add    (r_state == ST_CALC),
        .i_word   (w_calc_word),
        .i_fold   ((r_state == ST_FOLD) && (r_cnt == 4'd0)),
        .i_finish ((r_state == ST_FOLD) && (r_cnt == 4'd1)),
        .o_csum   (w_csum)
    );

    // Wire-order 16-bit word for the current beat; w_k is the index with the tag removed.
    always_comb begin
        w_word   = 16'h0000;
`ifdef VLAN_TAG_EN
        w_k      = (w_word_idx >= 5'd8) ? (w_word_idx - 5'd2) : w_word_idx;
`else
        w_k      = w_word_idx;
`endif
        w_ip_off = w_k[3:0] - 4'd7;
        case (w_k)
            5'd0:    w_word = r_dst_mac[47:32];
            5'd1:    w_word = r_dst_mac[31:16];
            5'd2:    w_word = r_dst_mac[15:0];
            5'd3:    w_word = r_src_mac[47:32];
            5'd4:    w_word = r_src_mac[31:16];
            5'd5:    w_word = r_src_mac[15:0];
            5'd6:    w_word = ETHERTYPE_IPV4;
            5'd17:   w_word = r_src_port;
            5'd18:   w_word = r_dst_port;
            5'd19:   w_word = r_udp_len;
            5'd20:   w_word = 16'h0000;
            default: w_word = (w_k >= 5'd7 && w_k <= 5'd16)
                            ? ip_word(w_ip_off, r_ip_len, r_ip_id, TTL, r_src_ip, r_dst_ip, w_csum)
                            : 16'h0000;
        endcase
`ifdef VLAN_TAG_EN
        if (w_word_idx == 5'd6)
            w_word = ETHERTYPE_VLAN;
        else if (w_word_idx == 5'd7)
            w_word = VLAN_TCI;
`endif
    end

    generate
        if (BUS_W == 16) begin : g_bus16
            assign w_word_idx = r_beat[4:0];
            assign w_beat     = {w_word[7:0], w_word[15:8]};
        end else begin : g_bus8
            assign w_word_idx = r_beat[5:1];
            assign w_beat     = r_beat[0] ? w_word[7:0] : w_word[15:8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_beat      <= '0;
            r_dst_mac   <= '0;
            r_src_mac   <= '0;
            r_dst_ip    <= '0;
            r_src_ip    <= '0;
            r_src_port  <= '0;
            r_dst_port  <= '0;
            r_ip_id     <= '0;
            r_ip_len    <= '0;
            r_udp_len   <= '0;
            r_busy      <= 1'b0;
            r_len_err   <= 1'b0;
            r_hdr_valid <= 1'b0;
            r_hdr_last  <= 1'b0;
            r_hdr_data  <= '0;
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (payload_len > MAX_UDP_PAYLOAD) begin
                            r_len_err <= 1'b1;
                        end else begin
                            r_dst_mac  <= dst_mac;
                            r_src_mac  <= src_mac;
                            r_dst_ip   <= dst_ip;
                            r_src_ip   <= src_ip;
                            r_src_port <= src_port;
                            r_dst_port <= dst_port;
                            r_ip_id    <= ip_id;
                            r_ip_len   <= payload_len + 16'(IP_HDR_BYTES + UDP_HDR_BYTES);
                            r_udp_len  <= payload_len + 16'(UDP_HDR_BYTES);
                            r_cnt      <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd9) begin
                        r_cnt   <= '0;
                        r_state <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_cnt   <= '0;
                        r_beat  <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!r_hdr_valid || hdr_ready) begin
                        if (r_hdr_valid && r_hdr_last) begin
                            r_hdr_valid <= 1'b0;
                            r_hdr_last  <= 1'b0;
                            r_hdr_data  <= '0;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_hdr_valid <= 1'b1;
                            r_hdr_data  <= w_beat;
                            r_hdr_last  <= (r_beat == LAST_BEAT);
                            r_beat      <= r_beat + 6'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hdr_data  = r_hdr_data;
    assign hdr_valid = r_hdr_valid;
    assign hdr_last  = r_hdr_last;
    assign busy      = r_busy;
    assign len_err   = r_len_err;

endmodule
